// File: rtl/apb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge: FSM state encoding and HTRANS codes.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } apb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_master_ctrl.sv
// AHB-to-APB master controller: one APB transfer per accepted AHB NONSEQ/SEQ beat,
// two-cycle AHB error response when the slave flags PSLVERR.
//
// state  | meaning
// IDLE   | no transfer; zero-wait OKAY to the AHB
// SETUP  | APB setup phase, psel_en=1, PENABLE=0
// ACCESS | APB access phase, waiting for PREADY
// ERR1   | first ERROR cycle, HREADYOUT=0
// ERR2   | second ERROR cycle, HREADYOUT=1; may accept the next transfer
module apb_master_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  psel_en,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  hresp_q, hresp_d;
    logic                  hready_q, hready_d;
    logic                  accept;
    logic                  load;

    assign accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    load    = 1'b1;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                // PSLVERR only matters on the completing cycle
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = ST_ERR1;
                    end else if (accept) begin
                        state_d = ST_SETUP;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase

        paddr_d  = load ? HADDR  : paddr_q;
        pwrite_d = load ? HWRITE : pwrite_q;

        // outputs registered from the next state so they change with the state flop
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        hresp_d   = (state_d == ST_ERR1) || (state_d == ST_ERR2);
        hready_d  = !((state_d == ST_SETUP) || (state_d == ST_ERR1));
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            hresp_q   <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hresp_q   <= hresp_d;
            hready_q  <= hready_d;
        end
    end

    // in ACCESS the AHB ready tracks the slave directly to avoid an extra wait state
    assign HREADYOUT = (state_q == ST_ACCESS) ? (PREADY && !PSLVERR) : hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (state_q == ST_ACCESS) ? PRDATA : '0;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign psel_en   = psel_q;
    assign PENABLE   = penable_q;
    assign PWDATA    = HWDATA;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a transfer-age reference model checked every cycle.
module tb_apb_master_ctrl;
    import apb_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        HRESETn, HSEL, HWRITE, PREADY, PSLVERR;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, PRDATA;
    logic        HREADY, HREADYOUT, HRESP, psel_en, PENABLE, PWRITE;
    logic [31:0] HRDATA, PADDR, PWDATA;

    int n_checks = 0;
    int n_errors = 0;

    assign HREADY = HREADYOUT;

    apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(clk), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .psel_en(psel_en),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age of the current APB transfer (0 none, 1 setup, >=2 access)
    // and remaining error-response cycles (2 then 1).
    int          m_age = 0;
    int          m_err = 0;
    logic [31:0] m_addr = '0;
    logic        m_wr = 1'b0;
    bit          started = 1'b0;
    logic        s_rstn = 1'b0, s_hsel = 1'b0, s_hwrite = 1'b0, s_pready = 1'b0, s_pslverr = 1'b0;
    logic        s_exp_hready = 1'b1;
    logic [1:0]  s_htrans = '0;
    logic [31:0] s_haddr = '0;

    always @(negedge clk) begin
        logic        e_hready;
        logic [31:0] e_hrdata;
        if (m_err == 2)      e_hready = 1'b0;
        else if (m_err == 1) e_hready = 1'b1;
        else if (m_age == 1) e_hready = 1'b0;
        else if (m_age >= 2) e_hready = PREADY && !PSLVERR;
        else                 e_hready = 1'b1;
        e_hrdata = (m_age >= 2) ? PRDATA : 32'h0;
        if (started) begin
            chk("m_psel_en", {31'b0, psel_en}, {31'b0, m_age > 0});
            chk("m_penable", {31'b0, PENABLE}, {31'b0, m_age >= 2});
            chk("m_hreadyout", {31'b0, HREADYOUT}, {31'b0, e_hready});
            chk("m_hresp", {31'b0, HRESP}, {31'b0, m_err > 0});
            chk("m_hrdata", HRDATA, e_hrdata);
            chk("m_paddr", PADDR, m_addr);
            chk("m_pwrite", {31'b0, PWRITE}, {31'b0, m_wr});
            chk("m_pwdata", PWDATA, HWDATA);
        end
        s_rstn = HRESETn; s_hsel = HSEL; s_htrans = HTRANS; s_haddr = HADDR;
        s_hwrite = HWRITE; s_pready = PREADY; s_pslverr = PSLVERR; s_exp_hready = e_hready;
    end

    always @(posedge clk) begin
        logic acc, start;
        acc   = s_hsel && s_exp_hready && s_htrans[1];
        start = 1'b0;
        if (!s_rstn) begin
            m_age = 0; m_err = 0; m_addr = '0; m_wr = 1'b0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_age >= 2) begin
            if (!s_pready)      m_age++;
            else if (s_pslverr) begin m_age = 0; m_err = 2; end
            else if (acc)       start = 1'b1;
            else                m_age = 0;
        end else if (m_err == 2) begin
            m_err = 1;
        end else begin
            m_err = 0;
            if (acc) start = 1'b1;
        end
        if (start) begin
            m_age = 1; m_err = 0; m_addr = s_haddr; m_wr = s_hwrite;
        end
        started = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic w);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = w;
    endtask

    task automatic noreq();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWRITE = 1'b0;
        HWDATA = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_psel", {31'b0, psel_en}, 32'd0);
        chk("rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("rst_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'b0, HRESP}, 32'd0);
        chk("rst_paddr", PADDR, 32'h0);
        tick(); HRESETn = 1'b1;
        tick();

        // write, zero slave wait
        req(32'h0000_2004, 1'b1); PREADY = 1'b1;
        tick(); noreq(); HWDATA = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_setup_psel", {31'b0, psel_en}, 32'd1);
        chk("wr_setup_pen", {31'b0, PENABLE}, 32'd0);
        chk("wr_setup_hready", {31'b0, HREADYOUT}, 32'd0);
        tick();
        @(negedge clk);
        chk("wr_acc_pen", {31'b0, PENABLE}, 32'd1);
        chk("wr_acc_paddr", PADDR, 32'h0000_2004);
        chk("wr_acc_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("wr_acc_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("wr_acc_hresp", {31'b0, HRESP}, 32'd0);
        tick();
        @(negedge clk);
        chk("wr_done_psel", {31'b0, psel_en}, 32'd0);

        // read with 3 PREADY-low cycles; PSLVERR asserted while not ready must be ignored
        req(32'h0000_0040, 1'b0); PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hAAAA_0000;
        tick(); noreq();
        low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!HREADYOUT) low++;
            tick();
        end
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h1234_5678;
        @(negedge clk);
        chk("rd_wait_lowcnt", low, 32'd4);
        chk("rd_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("rd_hrdata", HRDATA, 32'h1234_5678);
        chk("rd_pwrite", {31'b0, PWRITE}, 32'd0);
        tick();
        @(negedge clk);
        chk("rd_idle_hrdata", HRDATA, 32'h0);

        // slave error, then back-to-back accept in ERR2
        req(32'h0000_0080, 1'b1); PREADY = 1'b1; PSLVERR = 1'b1;
        tick(); noreq();
        tick();
        @(negedge clk);
        chk("err_acc_hready", {31'b0, HREADYOUT}, 32'd0);
        tick();
        @(negedge clk);
        chk("err1_hready", {31'b0, HREADYOUT}, 32'd0);
        chk("err1_hresp", {31'b0, HRESP}, 32'd1);
        chk("err1_psel", {31'b0, psel_en}, 32'd0);
        tick(); req(32'h0000_0050, 1'b0); PSLVERR = 1'b0;
        @(negedge clk);
        chk("err2_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("err2_hresp", {31'b0, HRESP}, 32'd1);
        tick(); noreq();
        @(negedge clk);
        chk("err2_b2b_psel", {31'b0, psel_en}, 32'd1);
        chk("err2_b2b_paddr", PADDR, 32'h0000_0050);
        chk("err2_b2b_hresp", {31'b0, HRESP}, 32'd0);
        tick(); tick();

        // two reads back-to-back
        req(32'h0000_1000, 1'b0);
        tick(); noreq();
        tick(); req(32'h0000_3000, 1'b0);
        @(negedge clk);
        chk("b2b_acc1_paddr", PADDR, 32'h0000_1000);
        chk("b2b_acc1_pen", {31'b0, PENABLE}, 32'd1);
        tick(); noreq();
        @(negedge clk);
        chk("b2b_setup2_psel", {31'b0, psel_en}, 32'd1);
        chk("b2b_setup2_pen", {31'b0, PENABLE}, 32'd0);
        chk("b2b_setup2_paddr", PADDR, 32'h0000_3000);
        tick(); tick();

        // BUSY with HSEL, and NONSEQ without HSEL, start nothing
        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h0000_0099;
        tick();
        @(negedge clk);
        chk("busy_psel", {31'b0, psel_en}, 32'd0);
        chk("busy_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("busy_hresp", {31'b0, HRESP}, 32'd0);
        HSEL = 1'b0; HTRANS = HTRANS_NONSEQ;
        tick();
        @(negedge clk);
        chk("nosel_psel", {31'b0, psel_en}, 32'd0);
        chk("nosel_paddr", PADDR, 32'h0000_3000);
        noreq();

        // reset during a stalled ACCESS
        req(32'h0000_0060, 1'b1); PREADY = 1'b0;
        tick(); noreq();
        tick(); HRESETn = 1'b0;
        @(negedge clk);
        chk("rstmid_pen", {31'b0, PENABLE}, 32'd1);
        tick(); HRESETn = 1'b1;
        @(negedge clk);
        chk("rstmid_psel", {31'b0, psel_en}, 32'd0);
        chk("rstmid_penable", {31'b0, PENABLE}, 32'd0);
        chk("rstmid_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("rstmid_paddr", PADDR, 32'h0);
        PREADY = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
